loop_idx_sequencer: RTL and testbench

- Programmable three-level loop-nest sequencer that walks a [D0][D1][D2] buffer (default [3][2][4] of 11-bit words) and emits one index/address beat per cycle over a valid/ready handshake.
- Sits between the layer controller (start/config) and the buffer read port / downstream PE array.
- Iteration bounds are runtime-configurable up to the physical dimensions.
- Address is computed from the physical layout.

---
 rtl/loop_idx_sequencer_pkg.sv | 21 ++
 rtl/loop_idx_sequencer_wrap_counter.sv | 27 ++
 rtl/loop_idx_sequencer.sv | 134 +++++++++++++
 tb/tb_loop_idx_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_idx_sequencer_pkg.sv
// Shared types and default geometry for the three-level loop-nest sequencer.
package lp_seq_pkg;

  localparam int LP_D0 = 3;
  localparam int LP_D1 = 2;
  localparam int LP_D2 = 4;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] k;
  } idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/loop_idx_sequencer_wrap_counter.sv
// Bounded up-counter: counts 0..bound-1 on en, flags the terminal count.
module wrap_counter
  import lp_seq_pkg::*;
#(
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] bound,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == bound - W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= wrap ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/loop_idx_sequencer.sv
// Walks a [D0][D1][D2] buffer under runtime bounds, one {i,j,k}/address beat per
// accepted handshake, k fastest.
module loop_idx_sequencer
  import lp_seq_pkg::*;
#(
  parameter int D0 = LP_D0,
  parameter int D1 = LP_D1,
  parameter int D2 = LP_D2,
  parameter int IW = IDX_W,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [IW-1:0]   cfg_n0,
  input  logic [IW-1:0]   cfg_n1,
  input  logic [IW-1:0]   cfg_n2,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [3*IW-1:0] o_idx,
  output logic [AW-1:0]   o_addr,
  output logic            o_last_k,
  output logic            o_last,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  state_t        state;
  logic [IW-1:0] n0, n1, n2;
  logic [AW-1:0] j_step, i_step;
  logic [AW-1:0] j_step_c, i_step_c;
  logic [IW-1:0] i_cnt, j_cnt, k_cnt;
  logic          wk, wj, wi;
  logic          cfg_ok, launch, kill, adv, last;
  idx_t          cur;

  always_comb begin
    cfg_ok = (cfg_n0 != '0) && (int'(cfg_n0) <= D0) &&
             (cfg_n1 != '0) && (int'(cfg_n1) <= D1) &&
             (cfg_n2 != '0) && (int'(cfg_n2) <= D2);
    launch = (state == IDLE) && start && cfg_ok;
    kill   = (state == RUN) && abort;
    adv    = (state == RUN) && o_ready && !abort;
    last   = wk && wj && wi;
    // Address deltas for row/plane wraps, fixed for the whole walk once latched.
    j_step_c = AW'(D2 - (int'(cfg_n2) - 1));
    i_step_c = AW'(D2 * D1 - (int'(cfg_n1) - 1) * D2 - (int'(cfg_n2) - 1));
  end

  wrap_counter #(.W(IW)) u_k (
    .clk(clk), .rst(rst), .en(adv), .clr(launch || kill),
    .bound(n2), .cnt(k_cnt), .wrap(wk)
  );

  wrap_counter #(.W(IW)) u_j (
    .clk(clk), .rst(rst), .en(adv && wk), .clr(launch || kill),
    .bound(n1), .cnt(j_cnt), .wrap(wj)
  );

  wrap_counter #(.W(IW)) u_i (
    .clk(clk), .rst(rst), .en(adv && wk && wj), .clr(launch || kill),
    .bound(n0), .cnt(i_cnt), .wrap(wi)
  );

  assign cur      = '{i: i_cnt, j: j_cnt, k: k_cnt};
  assign o_idx    = cur;
  assign o_last_k = o_valid && wk;
  assign o_last   = o_valid && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      n0      <= '0;
      n1      <= '0;
      n2      <= '0;
      j_step  <= '0;
      i_step  <= '0;
      o_addr  <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              n0      <= cfg_n0;
              n1      <= cfg_n1;
              n2      <= cfg_n2;
              j_step  <= j_step_c;
              i_step  <= i_step_c;
              o_addr  <= '0;
              state   <= RUN;
              o_valid <= 1'b1;
              busy    <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            busy    <= 1'b0;
            o_addr  <= '0;
          end else if (o_ready) begin
            if (last) begin
              state   <= DONE;
              o_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              o_addr  <= '0;
            end else if (!wk) begin
              o_addr <= o_addr + AW'(1);
            end else if (!wj) begin
              o_addr <= o_addr + j_step;
            end else begin
              o_addr <= o_addr + i_step;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_idx_sequencer.sv
// Scoreboard bench: driver pushes the expected beat list per walk, negedge monitor checks.
module tb_loop_idx_sequencer;
  import lp_seq_pkg::*;

  localparam int D0 = 3;
  localparam int D1 = 2;
  localparam int D2 = 4;
  localparam int IW = 3;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst, start, abort, o_ready;
  logic [IW-1:0]   cfg_n0, cfg_n1, cfg_n2;
  logic            o_valid, o_last_k, o_last, busy, done, cfg_err;
  logic [3*IW-1:0] o_idx;
  logic [AW-1:0]   o_addr;

  always #5 clk = ~clk;

  loop_idx_sequencer #(.D0(D0), .D1(D1), .D2(D2), .IW(IW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_n0(cfg_n0), .cfg_n1(cfg_n1), .cfg_n2(cfg_n2),
    .o_valid(o_valid), .o_ready(o_ready), .o_idx(o_idx), .o_addr(o_addr),
    .o_last_k(o_last_k), .o_last(o_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    int i;
    int j;
    int k;
    int addr;
    bit lk;
    bit l;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain nested loops over the configured bounds, row-major physical address.
  task automatic push_model(input int n0, input int n1, input int n2);
    for (int i = 0; i < n0; i++)
      for (int j = 0; j < n1; j++)
        for (int k = 0; k < n2; k++)
          exp_q.push_back('{i, j, k, (i * D1 + j) * D2 + k, k == n2 - 1,
                             (i == n0 - 1) && (j == n1 - 1) && (k == n2 - 1)});
  endtask

  logic            stalled = 1'b0;
  logic [3*IW-1:0] h_idx;
  logic [AW-1:0]   h_addr;
  logic            h_lk, h_l;

  always @(negedge clk) begin
    beat_t b;
    idx_t  got;
    if (!rst) chk("valid_vs_busy", o_valid, busy);
    if (!rst && o_valid) begin
      if (stalled) begin
        chk("hold_idx", o_idx, h_idx);
        chk("hold_addr", o_addr, h_addr);
        chk("hold_last_k", o_last_k, h_lk);
        chk("hold_last", o_last, h_l);
      end
      if (o_ready && !abort) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got addr %0d expected no beat at %0t", o_addr, $time);
        end else begin
          b   = exp_q.pop_front();
          got = o_idx;
          chk("idx_i", got.i, b.i);
          chk("idx_j", got.j, b.j);
          chk("idx_k", got.k, b.k);
          chk("addr", o_addr, b.addr);
          chk("last_k", o_last_k, b.lk);
          chk("last", o_last, b.l);
        end
        accepted++;
        stalled = 1'b0;
      end else begin
        stalled = !abort;
        h_idx   = o_idx;
        h_addr  = o_addr;
        h_lk    = o_last_k;
        h_l     = o_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_idx"}, o_idx, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_last_k"}, o_last_k, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  task automatic run_walk(input int n0, input int n1, input int n2, input bit rnd,
                          input int abort_at, input int rst_at);
    bit ok;
    int cyc, busy_cyc, total;
    bit got_done;
    ok = (n0 >= 1) && (n0 <= D0) && (n1 >= 1) && (n1 <= D1) && (n2 >= 1) && (n2 <= D2);
    total = n0 * n1 * n2;
    cyc = 0;
    busy_cyc = 0;
    got_done = 1'b0;
    @(posedge clk); #1;
    cfg_n0 = IW'(n0);
    cfg_n1 = IW'(n1);
    cfg_n2 = IW'(n2);
    o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    accepted = 0;
    exp_q.delete();
    if (ok) push_model(n0, n1, n2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!ok) begin
      chk("cfg_err_pulse", cfg_err, 1);
      chk("bad_cfg_valid", o_valid, 0);
      chk("bad_cfg_busy", busy, 0);
      repeat (3) begin
        @(posedge clk); #1;
        chk("cfg_err_once", cfg_err, 0);
        chk("bad_cfg_no_valid", o_valid, 0);
        chk("bad_cfg_no_busy", busy, 0);
      end
      return;
    end
    chk("no_cfg_err", cfg_err, 0);
    while (!got_done && cyc < 400) begin
      if (busy) busy_cyc++;
      if (abort_at >= 0 && accepted == abort_at) begin
        abort = 1'b1;
        o_ready = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", o_valid, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        repeat (3) begin
          @(posedge clk); #1;
          chk("abort_no_done", done, 0);
          chk("abort_idle_valid", o_valid, 0);
        end
        chk("abort_beats", accepted, abort_at);
        return;
      end
      if (rst_at >= 0 && accepted == rst_at) begin
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        chk_reset_vals("midrst_hold");
        rst = 1'b0;
        exp_q.delete();
        repeat (2) begin
          @(posedge clk); #1;
          chk("post_rst_idle", o_valid, 0);
        end
        return;
      end
      o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_n0 = IW'($urandom);
      cfg_n1 = IW'($urandom);
      cfg_n2 = IW'($urandom);
      start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      cyc++;
      chk("run_no_cfg_err", cfg_err, 0);
      if (done) begin
        got_done = 1'b1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("beat_count", accepted, total);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_busy_low", busy, 0);
    if (!rnd) begin
      chk("busy_cycles", busy_cyc, total);
      chk("done_latency", cyc, total);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", o_valid, 0);
  endtask

  initial begin
    int a, b, c;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    o_ready = 1'b0;
    cfg_n0 = '0;
    cfg_n1 = '0;
    cfg_n2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    run_walk(3, 2, 4, 0, -1, -1);
    run_walk(2, 1, 3, 0, -1, -1);
    run_walk(3, 2, 4, 1, -1, -1);
    run_walk(3, 2, 0, 0, -1, -1);
    run_walk(4, 2, 4, 0, -1, -1);
    run_walk(3, 2, 4, 0, 5, -1);
    run_walk(1, 1, 1, 0, -1, -1);
    run_walk(3, 2, 4, 0, -1, 10);
    run_walk(3, 2, 4, 0, -1, -1);

    // abort while idle must leave the block idle
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_valid", o_valid, 0);
    chk("idle_abort_busy", busy, 0);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom_range(0, 7);
        b = $urandom_range(0, 7);
        c = $urandom_range(0, 7);
      end else begin
        a = $urandom_range(1, D0);
        b = $urandom_range(1, D1);
        c = $urandom_range(1, D2);
      end
      run_walk(a, b, c, 1, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
